// File: rtl/seq_detect_pkg.sv
// Shared constants for the programmable serial sequence detector:
// power-up configuration and width helpers.
package seq_detect_pkg;

    localparam logic [31:0] DEF_PAT     = 32'h0000_0009;
    localparam int          DEF_LEN     = 4;
    localparam logic        DEF_OVERLAP = 1'b1;

    // Bits needed to hold a pattern length from 0 up to max_len inclusive.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Signal bundle between a bit-stream source and the sequence detector.
// x is consumed on any cycle with in_valid high and cfg_load low; there is no backpressure.
interface seq_detect_prog_if
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = len_width(MAX_LEN)
);
    logic               x;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               z;
    logic               z_q;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output x, in_valid, cfg_load, cfg_pat, cfg_len, cfg_overlap, cnt_clr,
        input  z, z_q, match_cnt
    );

    modport slave (
        input  x, in_valid, cfg_load, cfg_pat, cfg_len, cfg_overlap, cnt_clr,
        output z, z_q, match_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a synchronous clear overrides increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: shift-register history compared under a
// length mask, Mealy match flag, registered copy and saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_detect_prog_if.slave   bus
);
    logic [MAX_LEN-1:0] act_pat;
    logic [LEN_W-1:0]   act_len;
    logic               act_ovl;

    // Only MAX_LEN-1 past bits are needed: the newest window bit is x itself.
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic               z_q;

    logic               accept;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_p1;
    logic [LEN_W-1:0]   len_clamped;
    logic               z;
    logic [CNT_W-1:0]   cnt;

    always_comb begin
        accept  = 1'b0;
        cand    = '0;
        mask    = '0;
        fill_p1 = '0;
        z       = 1'b0;

        accept  = bus.in_valid && !bus.cfg_load;
        cand    = {hist, bus.x};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(act_len));
        end
        // fill >= len-1 rewritten as fill+1 >= len to avoid underflow at len 0.
        fill_p1 = {1'b0, fill} + (LEN_W + 1)'(1);
        z       = accept && (act_len != '0) && (fill_p1 >= {1'b0, act_len})
                  && (((cand ^ act_pat) & mask) == '0);
    end

    assign len_clamped = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_pat <= MAX_LEN'(DEF_PAT);
            act_len <= LEN_W'(DEF_LEN);
            act_ovl <= DEF_OVERLAP;
            hist    <= '0;
            fill    <= '0;
            z_q     <= 1'b0;
        end else begin
            z_q <= z;
            if (bus.cfg_load) begin
                act_pat <= bus.cfg_pat;
                act_len <= len_clamped;
                act_ovl <= bus.cfg_overlap;
                hist    <= '0;
                fill    <= '0;
            end else if (accept) begin
                hist <= cand[MAX_LEN-2:0];
                if (z && !act_ovl) begin
                    fill <= '0;
                end else if (fill != LEN_W'(MAX_LEN)) begin
                    fill <= fill + LEN_W'(1);
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (z),
        .clr   (bus.cnt_clr),
        .cnt   (cnt)
    );

    assign bus.z         = z;
    assign bus.z_q       = z_q;
    assign bus.match_cnt = cnt;
endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios with tabulated
// expected matches plus a randomized run against a bit-queue reference model.
module tb_seq_detect_prog;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) sif ();

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [0:0]       exp_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    // Reference model: bits received since the last clear, oldest first.
    logic               m_q[$];
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    logic               m_ovl;

    function automatic logic model_z(input logic xb);
        int base;
        if (m_len == 0) return 1'b0;
        if (m_q.size() < m_len - 1) return 1'b0;
        base = m_q.size() - (m_len - 1);
        for (int k = 0; k < m_len - 1; k++) begin
            if (m_q[base + k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return xb == m_pat[0];
    endfunction

    task automatic model_update(input logic xb, input logic zb);
        if (zb && !m_ovl) begin
            m_q.delete();
        end else begin
            m_q.push_back(xb);
            if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
        end
    endtask

    // One clock of stimulus; z checked mid-cycle, z_q and match_cnt after the edge.
    task automatic step(input string tag, input logic load, input logic v,
                        input logic xb, input logic clr, input logic exp_z);
        logic [0:0] e;
        sif.cfg_load = load;
        sif.in_valid = v;
        sif.x        = xb;
        sif.cnt_clr  = clr;
        exp_q.push_back(exp_z);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (sif.z !== e[0]) begin
            n_fail++;
            $display("FAIL %s z: got %b want %b", tag, sif.z, e[0]);
        end
        if (clr) exp_cnt = '0;
        else if (e[0] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (sif.z_q !== e[0]) begin
            n_fail++;
            $display("FAIL %s z_q: got %b want %b", tag, sif.z_q, e[0]);
        end
        n_cmp++;
        if (sif.match_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s match_cnt: got %0d want %0d", tag, sif.match_cnt, exp_cnt);
        end
        sif.cfg_load = 1'b0;
        sif.in_valid = 1'b0;
        sif.cnt_clr  = 1'b0;
    endtask

    task automatic load_cfg(input string tag, input logic [MAX_LEN-1:0] pat,
                            input int len, input logic ovl);
        sif.cfg_pat     = pat;
        sif.cfg_len     = LEN_W'(len);
        sif.cfg_overlap = ovl;
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        m_pat = pat;
        m_len = (len > MAX_LEN) ? MAX_LEN : len;
        m_ovl = ovl;
        m_q.delete();
    endtask

    // Drives n bits MSB-first, with the expected z for each bit in the same position.
    task automatic run_stream(input string tag, input logic [15:0] bits,
                              input logic [15:0] zs, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(tag, 1'b0, 1'b1, bits[i], 1'b0, zs[i]);
        end
    endtask

    task automatic test_reset();
        sif.in_valid = 1'b1;
        sif.x        = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (sif.z !== 1'b0) begin n_fail++; $display("FAIL reset z: got %b want 0", sif.z); end
        n_cmp++;
        if (sif.z_q !== 1'b0) begin n_fail++; $display("FAIL reset z_q: got %b want 0", sif.z_q); end
        n_cmp++;
        if (sif.match_cnt !== '0) begin n_fail++; $display("FAIL reset cnt: got %0d want 0", sif.match_cnt); end
        rst_n = 1'b1;
        sif.in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_cnt = '0;
    endtask

    task automatic test_default_overlap();
        run_stream("dflt_ovl", 16'b1001001, 16'b0001001, 7);
        n_cmp++;
        if (sif.match_cnt !== CNT_W'(2)) begin
            n_fail++; $display("FAIL dflt_ovl total: got %0d want 2", sif.match_cnt);
        end
    endtask

    task automatic test_non_overlap();
        load_cfg("nonovl_load", 8'b1001, 4, 1'b0);
        run_stream("nonovl", 16'b1001001, 16'b0001000, 7);
        n_cmp++;
        if (sif.match_cnt !== CNT_W'(3)) begin
            n_fail++; $display("FAIL nonovl total: got %0d want 3", sif.match_cnt);
        end
        step("clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_gap();
        load_cfg("gap_load", 8'b110, 3, 1'b1);
        step("gap", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("gap", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("gap_idle", 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step("gap_idle", 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step("gap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_stream("gap", 16'b110, 16'b001, 3);
        n_cmp++;
        if (sif.match_cnt !== CNT_W'(2)) begin
            n_fail++; $display("FAIL gap total: got %0d want 2", sif.match_cnt);
        end
    endtask

    task automatic test_saturate();
        step("sat_clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        load_cfg("sat_load", 8'b1, 1, 1'b1);
        for (int i = 0; i < 5; i++) step("sat", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (sif.match_cnt !== CNT_W'(3)) begin
            n_fail++; $display("FAIL sat hold: got %0d want 3", sif.match_cnt);
        end
        step("sat_clr_win", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (sif.match_cnt !== '0) begin
            n_fail++; $display("FAIL sat clr_wins: got %0d want 0", sif.match_cnt);
        end
        step("len1_zero", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_len_zero();
        load_cfg("len0_load", 8'hFF, 0, 1'b1);
        for (int i = 0; i < 10; i++) step("len0", 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic test_clamp();
        load_cfg("clamp_load", 8'b10110011, 15, 1'b1);
        run_stream("clamp", 16'b1010110011, 16'b0000000001, 10);
    endtask

    task automatic test_reset_mid();
        load_cfg("rmid_load", 8'b1011, 4, 1'b0);
        load_cfg("rmid_load", 8'b1001, 4, 1'b1);
        run_stream("rmid_pre", 16'b100, 16'b000, 3);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (sif.match_cnt !== '0 || sif.z_q !== 1'b0) begin
            n_fail++; $display("FAIL rmid reset: got cnt %0d z_q %b want 0 0", sif.match_cnt, sif.z_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt = '0;
        step("rmid_after", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_stream("rmid_post", 16'b1001, 16'b0001, 4);
    endtask

    task automatic test_load_discard();
        run_stream("ldisc_pre", 16'b100, 16'b000, 3);
        sif.cfg_pat     = 8'b1001;
        sif.cfg_len     = LEN_W'(4);
        sif.cfg_overlap = 1'b1;
        step("ldisc_load", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_stream("ldisc_post", 16'b1001, 16'b0001, 4);
    endtask

    task automatic test_random();
        logic v, xb, zb, clr;
        for (int c = 0; c < 4; c++) begin
            load_cfg("rnd_load", MAX_LEN'($urandom_range(0, 255)), $urandom_range(1, 4),
                     1'($urandom_range(0, 1)));
            for (int i = 0; i < 60; i++) begin
                v   = ($urandom_range(0, 9) < 8);
                xb  = 1'($urandom_range(0, 1));
                clr = ($urandom_range(0, 19) == 0);
                zb  = v ? model_z(xb) : 1'b0;
                step("rnd", 1'b0, v, xb, clr, zb);
                if (v) model_update(xb, zb);
            end
        end
    endtask

    initial begin
        sif.x           = 1'b0;
        sif.in_valid    = 1'b0;
        sif.cfg_load    = 1'b0;
        sif.cfg_pat     = '0;
        sif.cfg_len     = '0;
        sif.cfg_overlap = 1'b0;
        sif.cnt_clr     = 1'b0;
        m_pat = 8'b1001;
        m_len = 4;
        m_ovl = 1'b1;

        test_reset();
        test_default_overlap();
        test_non_overlap();
        test_gap();
        test_saturate();
        test_len_zero();
        test_clamp();
        test_reset_mid();
        test_load_discard();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter: MAX_LEN, 8, maximum pattern length in bits (2..32).
REQ-002 Parameter: CNT_W, 8, match-counter width.
REQ-003 Parameter: LEN_W, $clog2(MAX_LEN+1), width of the pattern-length field.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 x  input  1  serial data bit.
REQ-007 in_valid  input  1  x is sampled only when high.
REQ-008 cfg_load  input  1  one-cycle strobe; latches cfg_pat, cfg_len and cfg_overlap.
REQ-009 cfg_pat  input  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
REQ-010 cfg_len  input  LEN_W  pattern length.
REQ-011 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 cnt_clr  input  1  synchronous clear of the match counter.
REQ-013 z  output  1  Mealy match flag, combinational from state, x and in_valid.
REQ-014 z_q  output  1  z registered; high in the cycle after z.
REQ-015 match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-016 Active config holds pattern, length and overlap; the detector keeps a history of the last up to MAX_LEN accepted bits plus a fill count.
REQ-017 z SHALL be high when in_valid=1, cfg_load=0, the fill count is at least len-1, and the last len-1 history bits followed by x equal the pattern.
REQ-018 z SHALL be low whenever in_valid=0, cfg_load=1, or the active len is 0.
REQ-019 On an accepted bit (in_valid=1, cfg_load=0), the bit is shifted into the history and the fill count increments, saturating at MAX_LEN.
REQ-020 Overlap=1: after a match the history is kept, so the pattern suffix can start the next match.
REQ-021 Overlap=0: on a match the fill count is cleared to 0 in the same edge, so no bit of the matched pattern is reused.
REQ-022 cfg_len greater than MAX_LEN SHALL be clamped to MAX_LEN at load; cfg_len=0 disables detection.
REQ-023 cfg_len=1: every accepted x equal to cfg_pat[0] matches.
REQ-024 cfg_load SHALL clear the history and fill count and discard any same-cycle in_valid bit; the new config applies from the next cycle.
REQ-025 match_cnt SHALL increment by 1 on each cycle with z=1 and hold at 2^CNT_W-1 once reached.
REQ-026 If cnt_clr and z are both high in the same cycle, cnt_clr wins and match_cnt becomes 0.
REQ-027 cfg_load SHALL NOT affect match_cnt.
REQ-028 Latency: z has zero cycles from the final x bit; z_q and match_cnt update one cycle after it.

Reset
REQ-029 While rst_n=0, the active config SHALL be pattern 4'b1001, len 4, overlap 1.
REQ-030 While rst_n=0, history, fill count, z_q and match_cnt SHALL be 0, and z SHALL therefore be 0.
REQ-031 Reset asserted mid-pattern SHALL discard the partial match; detection restarts from an empty history after release.

Structure
REQ-032 Package seq_detect_pkg SHALL hold DEF_PAT, DEF_LEN, DEF_OVERLAP and the width helpers.
REQ-033 The match counter SHALL be a sub-module sat_counter, parameterised by width, with inc and clr inputs.
REQ-034 The history is a shift register; pattern comparison uses a masked compare over the active length, with no per-pattern FSM.

Verification
REQ-035 Default config, stream 1,0,0,1,0,0,1 -> z high on bits 4 and 7, match_cnt=2.
REQ-036 Load cfg_overlap=0, then the same stream -> z high on bit 4 only, match_cnt increments by 1.
REQ-037 Load cfg_pat=3'b110, cfg_len=3, stream 1,1,0,1,1,0 with in_valid low between bits 2 and 3 for two cycles -> z high on bits 3 and 6, and never while in_valid=0.
REQ-038 With CNT_W=2, drive 5 matches -> match_cnt=3 and holds; cnt_clr coincident with the 6th match -> match_cnt=0.
REQ-039 Default config, drive 1,0,0, then pulse rst_n low, release, then drive 1 -> no z; then drive 1,0,0,1 -> z on the final 1.
REQ-040 Drive 1,0,0, then cfg_load with the default config while in_valid=1 and x=1 -> no z, and that bit is discarded; a following 1,0,0,1 -> exactly one z.
